// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 5-stage RV64 core. Owns instruction memory
//   (combinational fetch on pc) and data memory (shared tri-state mem_data
//   bus). A host loader fills both memories while the core is held in reset.
//   A post-load hold counter then releases the core into RUN.
//
// Optional feature macro: MEM_RESPONDER_BOUNDS_EN
//   Defined   : out-of-range indices set err_oor. Writes are suppressed,
//               data reads drive 0 and fetches return a NOP.
//   Undefined : indices wrap modulo depth and err_oor is tied low.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   pc / inst       : fetch byte address / instruction (NOP while held)
//   addr            : data byte address (EX_MEM_result)
//   mem_rw          : 1 = core drives mem_data (store)
//   mem_rd          : load strobe; 0 keeps the bus released
//   mem_data        : shared 64-bit tri-state data bus
//   cpu_hold        : drives the core's reset
//   ld_valid/ready  : loader beat handshake
//   ld_sel          : 0 = imem, 1 = dmem
//   ld_addr/ld_data : word index / beat data
//   ld_last         : final beat of the load
//   err_align       : sticky misaligned-access flag
//   err_oor         : sticky out-of-range flag
//   o_dbg_state     : FSM state (0 LOAD, 1 HOLD, 2 RUN) for observation
//
// Loader handshake: a beat transfers on a rising edge where ld_valid and
// ld_ready are both high. ld_ready depends only on the FSM state and never
// on ld_valid. A beat presented while rst is high is not written.
module mem_responder #(
  parameter int IMEM_WORDS  = 1024,
  parameter int DMEM_WORDS  = 512,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [63:0] addr,
  input  logic        mem_rw,
  input  logic        mem_rd,
  inout  wire  [63:0] mem_data,
  output logic        cpu_hold,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [31:0] ld_addr,
  input  logic [63:0] ld_data,
  input  logic        ld_last,
  output logic        err_align,
  output logic        err_oor,
  output logic [1:0]  o_dbg_state
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_hold_cnt;
  logic        r_cpu_hold;
  logic        r_ld_ready;
  logic        r_err_align;
  logic        r_err_oor;

  logic [31:0] r_imem [IMEM_WORDS];
  logic [63:0] r_dmem [DMEM_WORDS];

  // Truncated indices and range checks on the bits above them.
  logic [IAW-1:0] w_i_idx, w_li_idx;
  logic [DAW-1:0] w_d_idx, w_ld_idx;
  logic           w_i_oor, w_d_oor, w_li_oor, w_ld_oor;
  logic           w_i_blk, w_d_blk, w_li_blk, w_ld_blk;
  logic           w_oor_hit;
  logic           w_run, w_ld_acc, w_d_access, w_drive;
  logic [63:0]    w_rd_data;
  logic           w_unused_pc;

  assign w_i_idx  = pc[IAW+1:2];
  assign w_d_idx  = addr[DAW+2:3];
  assign w_li_idx = ld_addr[IAW-1:0];
  assign w_ld_idx = ld_addr[DAW-1:0];
  assign w_i_oor  = |pc[31:IAW+2];
  assign w_d_oor  = |addr[63:DAW+3];
  assign w_li_oor = |ld_addr[31:IAW];
  assign w_ld_oor = |ld_addr[31:DAW];
  assign w_unused_pc = ^pc[1:0];

  assign w_run      = (r_state == ST_RUN);
  assign w_ld_acc   = r_ld_ready && ld_valid;
  assign w_d_access = w_run && (mem_rw || mem_rd);
  assign w_drive    = w_run && !mem_rw && mem_rd;

`ifdef MEM_RESPONDER_BOUNDS_EN
  assign w_i_blk  = w_i_oor;
  assign w_d_blk  = w_d_oor;
  assign w_li_blk = w_li_oor;
  assign w_ld_blk = w_ld_oor;
  // A fetch only counts once the core is actually running.
  assign w_oor_hit = (w_ld_acc && (ld_sel ? w_ld_oor : w_li_oor)) ||
                     (w_d_access && w_d_oor) ||
                     (!r_cpu_hold && w_i_oor);
`else
  logic w_unused_oor;
  assign w_i_blk   = 1'b0;
  assign w_d_blk   = 1'b0;
  assign w_li_blk  = 1'b0;
  assign w_ld_blk  = 1'b0;
  assign w_oor_hit = 1'b0;
  assign w_unused_oor = w_i_oor ^ w_d_oor ^ w_li_oor ^ w_ld_oor;
`endif

  assign inst      = (r_cpu_hold || w_i_blk) ? NOP : r_imem[w_i_idx];
  assign w_rd_data = w_d_blk ? 64'd0 : r_dmem[w_d_idx];
  // The bus is never driven while the core stores (mem_rw = 1).
  assign mem_data  = w_drive ? w_rd_data : 64'bz;

  assign cpu_hold    = r_cpu_hold;
  assign ld_ready    = r_ld_ready;
  assign err_align   = r_err_align;
  assign err_oor     = r_err_oor;
  assign o_dbg_state = r_state;

  // Control FSM. cpu_hold is registered from the previous state. The core
  // therefore stays in reset for one cycle after the FSM reaches RUN. This
  // places the release exactly HOLD_CYCLES+1 edges after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_hold_cnt  <= 4'd0;
      r_cpu_hold  <= 1'b1;
      r_ld_ready  <= 1'b1;
      r_err_align <= 1'b0;
      r_err_oor   <= 1'b0;
    end else begin
      r_cpu_hold <= (r_state != ST_RUN);
      case (r_state)
        ST_LOAD: begin
          if (w_ld_acc && ld_last) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HOLD_LOAD;
            r_ld_ready <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == 4'd0) r_state <= ST_RUN;
          else                    r_hold_cnt <= r_hold_cnt - 4'd1;
        end
        ST_RUN: ;
        default: begin
          r_state    <= ST_LOAD;
          r_ld_ready <= 1'b1;
        end
      endcase
      if (w_d_access && (addr[2:0] != 3'd0)) r_err_align <= 1'b1;
      if (w_oor_hit) r_err_oor <= 1'b1;
    end
  end

  // Memory arrays have no reset, so their contents survive rst and reload.
  always_ff @(posedge clk) begin
    if (!rst && w_ld_acc && !ld_sel && !w_li_blk)
      r_imem[w_li_idx] <= ld_data[31:0];
  end

  // Loader writes happen only in LOAD and core stores only in RUN, so the
  // two write sources never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ld_acc && ld_sel && !w_ld_blk)
        r_dmem[w_ld_idx] <= ld_data;
      else if (w_run && mem_rw && !w_d_blk)
        r_dmem[w_d_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc = '0;
  logic [31:0] inst;
  logic [63:0] addr = '0;
  logic        mem_rw = 1'b0;
  logic        mem_rd = 1'b0;
  wire  [63:0] mem_data;
  logic        cpu_hold;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_sel = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [63:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        err_align;
  logic        err_oor;
  logic [1:0]  dbg_state;

  logic        tb_drv = 1'b0;
  logic [63:0] tb_val = '0;
  assign mem_data = tb_drv ? tb_val : 64'bz;

  int n_tests = 0;
  int n_fail  = 0;
  int edges;
  logic released;

  localparam logic [63:0] ST_LOAD = 64'd0;
  localparam logic [63:0] ST_HOLD = 64'd1;
  localparam logic [63:0] ST_RUN  = 64'd2;

  mem_responder #(
    .IMEM_WORDS(1024), .DMEM_WORDS(512), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .addr(addr),
    .mem_rw(mem_rw), .mem_rd(mem_rd), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .err_align(err_align), .err_oor(err_oor),
    .o_dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input logic sel, input logic [31:0] a, input logic [63:0] d,
                      input logic last);
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d; ld_last = last;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Counts rising edges until cpu_hold drops, bounded to 20.
  task automatic wait_release(output int n);
    n = 0;
    while (cpu_hold === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Time limit on the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_err_align", 64'(err_align), 64'd0);
    chk("rst_err_oor", 64'(err_oor), 64'd0);
    chk("rst_inst_nop", 64'(inst), 64'h13);
    chk("rst_state", 64'(dbg_state), ST_LOAD);
    released = (mem_data === 64'bz) || (mem_data === 64'd0);
    chk("rst_bus_z", 64'(released), 64'd1);
    rst = 1'b0;

    // Load: dmem words, then imem program with last beat
    beat(1'b0, 32'd6, 64'h0000_0666, 1'b0);
    beat(1'b1, 32'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);
    beat(1'b1, 32'd3, 64'h1111_2222_3333_4444, 1'b0);
    beat(1'b1, 32'd4, 64'h0000_0000_0000_4444, 1'b0);
    beat(1'b0, 32'd0, 64'h0050_0093, 1'b0);
    beat(1'b0, 32'd1, 64'h00A0_0113, 1'b0);
    beat(1'b0, 32'd2, 64'h0020_81B3, 1'b1);
    #1;
    chk("hold_ld_ready", 64'(ld_ready), 64'd0);
    chk("hold_state", 64'(dbg_state), ST_HOLD);
    pc = 32'd4;
    #1;
    chk("hold_inst_nop", 64'(inst), 64'h13);
    wait_release(edges);
    chk("hold_release_edges", 64'(edges), 64'd5);
    chk("run_state", 64'(dbg_state), ST_RUN);
    chk("fetch_pc4", 64'(inst), 64'h00A0_0113);
    pc = 32'd8; #1;
    chk("fetch_pc8", 64'(inst), 64'h0020_81B3);
    pc = 32'd0; #1;
    chk("fetch_pc0", 64'(inst), 64'h0050_0093);

    // Store then read back the same index
    @(negedge clk);
    addr = 64'h10; mem_rw = 1'b1; tb_drv = 1'b1; tb_val = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    tb_drv = 1'b0; mem_rw = 1'b0; mem_rd = 1'b1;
    #1;
    chk("store_readback", mem_data, 64'hDEAD_BEEF_0000_0001);
    mem_rd = 1'b0; #1;
    released = (mem_data === 64'bz) || (mem_data === 64'd0);
    chk("rd0_bus_z", 64'(released), 64'd1);
    chk("aligned_no_err", 64'(err_align), 64'd0);
    addr = 64'h18; mem_rd = 1'b1; #1;
    chk("loader_dmem3", mem_data, 64'h1111_2222_3333_4444);
    mem_rd = 1'b0;

    // Misaligned read
    @(negedge clk);
    addr = 64'h13; mem_rd = 1'b1; #1;
    chk("misalign_data", mem_data, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk); #1;
    chk("misalign_flag", 64'(err_align), 64'd1);
    addr = 64'h18;
    repeat (3) @(negedge clk);
    #1;
    chk("misalign_sticky", 64'(err_align), 64'd1);
    mem_rd = 1'b0;

    // Bounds: addr 0x1000 is past the 512-doubleword data memory
    @(negedge clk);
    addr = 64'h1000; mem_rd = 1'b1; #1;
`ifdef MEM_RESPONDER_BOUNDS_EN
    chk("oor_read", mem_data, 64'd0);
`else
    chk("oor_read", mem_data, 64'hA5A5_A5A5_5A5A_5A5A);
`endif
    @(negedge clk);
    mem_rd = 1'b0; mem_rw = 1'b1; tb_drv = 1'b1; tb_val = 64'h0BAD_F00D_0000_0055;
    @(negedge clk);
    tb_drv = 1'b0; mem_rw = 1'b0; mem_rd = 1'b1; addr = 64'h0; #1;
`ifdef MEM_RESPONDER_BOUNDS_EN
    chk("oor_store", mem_data, 64'hA5A5_A5A5_5A5A_5A5A);
    chk("oor_flag", 64'(err_oor), 64'd1);
`else
    chk("oor_store", mem_data, 64'h0BAD_F00D_0000_0055);
    chk("oor_flag", 64'(err_oor), 64'd0);
`endif
    mem_rd = 1'b0;

    // Loader beat while running is refused
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 32'd0; ld_data = 64'hFFFF_FFFF; ld_last = 1'b1;
    #1;
    chk("run_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; pc = 32'd0; #1;
    chk("run_beat_ignored", 64'(inst), 64'h0050_0093);
    chk("run_state_kept", 64'(dbg_state), ST_RUN);

    // Reset in RUN during a store: store dropped
    @(negedge clk);
    rst = 1'b1; addr = 64'h20; mem_rw = 1'b1; tb_drv = 1'b1; tb_val = 64'h7777;
    @(negedge clk);
    rst = 1'b0; mem_rw = 1'b0; tb_drv = 1'b0; #1;
    chk("rrst_state", 64'(dbg_state), ST_LOAD);
    chk("rrst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rrst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rrst_err_align", 64'(err_align), 64'd0);
    chk("rrst_err_oor", 64'(err_oor), 64'd0);
    chk("rrst_inst_nop", 64'(inst), 64'h13);

    // Reset during the second beat of a load
    beat(1'b0, 32'd5, 64'h1111_1111, 1'b0);
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 32'd6; ld_data = 64'h2222_2222; rst = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b0; #1;
    chk("mid_rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("mid_rst_state", 64'(dbg_state), ST_LOAD);
    beat(1'b0, 32'd7, 64'h3333_3333, 1'b1);
    wait_release(edges);
    chk("reload_release", 64'(edges), 64'd5);
    pc = 32'd0; #1;
    chk("reload_pc0_kept", 64'(inst), 64'h0050_0093);
    pc = 32'd20; #1;
    chk("reload_beat0", 64'(inst), 64'h1111_1111);
    pc = 32'd24; #1;
    chk("rst_beat_not_written", 64'(inst), 64'h0000_0666);
    pc = 32'd28; #1;
    chk("reload_last", 64'(inst), 64'h3333_3333);
    addr = 64'h20; mem_rd = 1'b1; #1;
    chk("rst_store_dropped", mem_data, 64'h4444);
    mem_rd = 1'b0;

    // ---------------- report ----------------
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 5-stage RV64 core: owns instruction memory (answers `pc` with `inst`) and data memory (answers the core's tri-state `mem_data` bus, addressed by `EX_MEM_result`, direction `EX_MEM_mem_rw`). A host-side loader port fills both memories while the core is held in reset. A post-load hold counter then releases the core into RUN.

## Interface

Parameters:
- `IMEM_WORDS`, 1024: instruction memory depth, 32-bit words, power of two.
- `DMEM_WORDS`, 512: data memory depth, 64-bit doublewords, power of two.
- `HOLD_CYCLES`, 4: cycles `cpu_hold` stays high after the last load beat; range 1..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `pc`, input, 32: core fetch address, byte address.
- `inst`, output, 32: instruction at `pc`.
- `addr`, input, 64: data address, byte address; connects to `EX_MEM_result`.
- `mem_rw`, input, 1: 1 = core drives `mem_data` (store); 0 = read allowed.
- `mem_rd`, input, 1: load strobe (EX/MEM load flag); tie to 1 if unavailable.
- `mem_data`, inout, 64: shared data bus.
- `cpu_hold`, output, 1: drives the core's `rst`.
- `ld_valid`, input, 1: loader beat valid.
- `ld_ready`, output, 1: loader beat accepted when high together with `ld_valid`.
- `ld_sel`, input, 1: 0 = imem, 1 = dmem.
- `ld_addr`, input, 32: word index; imem uses 32-bit words, dmem uses doublewords.
- `ld_data`, input, 64: beat data; imem takes bits [31:0].
- `ld_last`, input, 1: final beat of the load.
- `err_align`, output, 1: sticky flag, misaligned data access.
- `err_oor`, output, 1: sticky flag, out-of-range access (see Configuration).

## Operation

- FSM states:
  - LOAD (entered on reset): `ld_ready`=1, `cpu_hold`=1.
  - HOLD: `ld_ready`=0, `cpu_hold`=1; 4-bit counter loaded with `HOLD_CYCLES`-1, decrements each cycle.
  - RUN: `ld_ready`=0, `cpu_hold`=0.
- Transitions:
  - LOAD→HOLD on an accepted beat with `ld_last`=1.
  - HOLD→RUN when the counter = 0.
  - RUN persists until `rst`.
  - `rst` in any state → LOAD.
- Loader write:
  - An accepted beat writes `ld_data` to the selected memory at index `ld_addr`, modulo depth or OOR-checked.
  - Beats with `ld_valid`=0 are ignored.
- Instruction read:
  - Combinational: `inst` = imem[`pc`[log2(IMEM_WORDS)+1:2]].
  - `inst` = 0x00000013 (`addi x0,x0,0`) whenever `cpu_hold`=1.
- Data read:
  - In RUN with `mem_rw`=0 and `mem_rd`=1, `mem_data` is driven combinationally with dmem[`addr`[log2(DMEM_WORDS)+2:3]].
  - Otherwise `mem_data` = Z. The block never drives the bus while `mem_rw`=1.
- Data write:
  - In RUN with `mem_rw`=1, the posedge writes `mem_data` into dmem at that index.
  - `mem_rw` and `mem_rd` are ignored outside RUN.
- Alignment:
  - A RUN access (`mem_rw`, or `mem_rd`) with `addr`[2:0]≠0 sets `err_align`.
  - The access is still performed on the truncated index.
- Memory arrays are not cleared by `rst`; contents survive reset and reload.

## Timing

- Reset values: state=LOAD, `cpu_hold`=1, `ld_ready`=1, `err_align`=0, `err_oor`=0, `inst`=0x00000013, `mem_data`=Z, hold counter=0.
- Loader: one beat per cycle max; `ld_ready` depends only on state, never on `ld_valid`.
- Last beat at edge N: `cpu_hold` high through cycle N+`HOLD_CYCLES`, low from edge N+`HOLD_CYCLES`+1.
- Data read latency 0: the core samples `mem_data` at the same edge that ends its MEM cycle.
- Store latency 1: a read of the same index on the next cycle returns the new value.
- Error flags set at the edge of the offending access, remain set until `rst`.
- `rst` mid-load: state→LOAD; words already written are retained; a beat presented with `rst` high is not written.
- `rst` in RUN while `mem_rw`=1: the store is dropped.

## Configuration

- `MEM_RESPONDER_BOUNDS_EN` defined:
  - Any data access or loader beat whose index ≥ depth sets `err_oor`.
  - The write is suppressed; a read drives 0.
  - An imem fetch out of range returns 0x00000013 and sets `err_oor`.
- Undefined: indices wrap modulo depth; `err_oor` tied 0.

## Test plan

- Load 3 imem beats (0→0x00500093, 1→0x00A00113, 2 with `ld_last`→0x002081B3), `HOLD_CYCLES`=4 → `cpu_hold` falls exactly 5 edges after the last beat; `pc`=4 gives `inst`=0x00A00113; `inst`=0x13 while held.
- RUN, `addr`=0x10, `mem_rw`=1, bus driven 0xDEADBEEF_00000001 → next cycle with `mem_rw`=0, `mem_rd`=1 the block drives 0xDEADBEEF_00000001; with `mem_rd`=0 the bus reads Z.
- `addr`=0x13 with `mem_rd`=1 → `err_align`=1, data from index 2, flag held until `rst`.
- Bounds, DMEM_WORDS=512, `addr`=0x1000:
  - With `MEM_RESPONDER_BOUNDS_EN`: store suppressed, read drives 0, `err_oor`=1.
  - Without it: access aliases index 0, `err_oor`=0.
- Assert `rst` during a 2nd-beat loader transfer → beat not written, state LOAD, `ld_ready`=1, previously loaded beat 0 still readable after a reload finishes.
- Loader beat with `ld_valid`=1 in RUN → `ld_ready`=0, memory unchanged.
